conv_window_gen: RTL and testbench

- Parametrised streaming 3x3 window generator. It replaces the fixed-geometry window front-end inside each LayerN block.
- Accepts one raster-order pixel per Valid_In (CHANNEL_IN packed words) and holds two line buffers.
- Emits the full 3x3xCHANNEL_IN neighbourhood for each output position, with a programmable stride and an optional zero padding.
- Feeds the per-layer MAC array. The block is data-agnostic (words are passed through untouched).

---
 rtl/conv_window_gen.sv | 162 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3xCHANNEL_IN window generator: two line buffers, a 3x3 shift window and a programmable stride.
// Define CONV_WINDOW_ZERO_PAD_EN to add a 1-pixel zero border injected by a small state machine.
module conv_window_gen #(
    parameter int DATA_WIDHT = 32,
    parameter int CHANNEL_IN = 8,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44,
    parameter int STRIDE     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 Valid_In,
    input  logic [DATA_WIDHT*CHANNEL_IN-1:0]     Data_In,
    output logic                                 In_Ready,
    output logic [9*DATA_WIDHT*CHANNEL_IN-1:0]   Data_Out,
    output logic                                 Valid_Out,
    output logic                                 Frame_Done
);
    localparam int PW = DATA_WIDHT * CHANNEL_IN;
`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam int WI = IMG_WIDHT + 2;
    localparam int HI = IMG_HEIGHT + 2;
`else
    localparam int WI = IMG_WIDHT;
    localparam int HI = IMG_HEIGHT;
`endif
    localparam int CW       = $clog2(WI);
    localparam int RW       = $clog2(HI);
    localparam int LAST_ROW = 2 + ((HI - 3) / STRIDE) * STRIDE;
    localparam int LAST_COL = 2 + ((WI - 3) / STRIDE) * STRIDE;

    localparam logic [CW-1:0] COL_MAX  = CW'(WI - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(HI - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(LAST_COL);
    localparam logic [RW-1:0] ROW_LAST = RW'(LAST_ROW);

    logic          px_valid;
    logic [PW-1:0] px_data;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

`ifdef CONV_WINDOW_ZERO_PAD_EN
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PAD_TOP    = 3'd1;
    localparam logic [2:0] ROW_LEFT   = 3'd2;
    localparam logic [2:0] ROW_DATA   = 3'd3;
    localparam logic [2:0] ROW_RIGHT  = 3'd4;
    localparam logic [2:0] PAD_BOTTOM = 3'd5;

    localparam logic [CW-1:0] COL_DATA_END = CW'(WI - 2);
    localparam logic [RW-1:0] ROW_DATA_END = RW'(HI - 2);

    logic [2:0] state, state_nxt;

    // The padded-geometry counters double as the FSM's position tracker.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_nxt = state;
        px_valid  = 1'b0;
        px_data   = '0;
        In_Ready  = 1'b0;
        case (state)
            IDLE:       if (Valid_In) state_nxt = PAD_TOP;
            PAD_TOP: begin
                px_valid = 1'b1;
                if (col == COL_MAX) state_nxt = ROW_LEFT;
            end
            ROW_LEFT: begin
                px_valid  = 1'b1;
                state_nxt = ROW_DATA;
            end
            ROW_DATA: begin
                In_Ready = 1'b1;
                px_valid = Valid_In;
                px_data  = Data_In;
                if (Valid_In && col == COL_DATA_END) state_nxt = ROW_RIGHT;
            end
            ROW_RIGHT: begin
                px_valid  = 1'b1;
                state_nxt = (row == ROW_DATA_END) ? PAD_BOTTOM : ROW_LEFT;
            end
            PAD_BOTTOM: begin
                px_valid = 1'b1;
                if (col == COL_MAX) state_nxt = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
`else
    assign In_Ready = rst;
    assign px_valid = Valid_In && In_Ready;
    assign px_data  = Data_In;
`endif

    logic complete;
    assign complete = (int'(row) >= 2) && (int'(col) >= 2) &&
                      ((int'(row) - 2) % STRIDE == 0) && ((int'(col) - 2) % STRIDE == 0);

    // lb0 holds the previous row, lb1 the row before it, both addressed by column.
    logic [PW-1:0] lb0 [WI];
    logic [PW-1:0] lb1 [WI];
    logic [PW-1:0] win [3][3];
    logic [PW-1:0] up1, up2;

    assign up1 = lb0[col];
    assign up2 = lb1[col];

    // NOTE: line buffers and window registers have no reset; the row/col gating decides when they are valid.
    always_ff @(posedge clk) begin
        if (px_valid) begin
            lb0[col] <= px_data;
            lb1[col] <= up1;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= up2;
            win[1][2] <= up1;
            win[2][2] <= px_data;
        end
    end

    logic [9*PW-1:0] win_flat;
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            win_flat[(r*3+0)*PW +: PW] = win[r][1];
            win_flat[(r*3+1)*PW +: PW] = win[r][2];
        end
        win_flat[2*PW +: PW] = up2;
        win_flat[5*PW +: PW] = up1;
        win_flat[8*PW +: PW] = px_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            Data_Out   <= '0;
        end else begin
            Valid_Out  <= px_valid && complete;
            Frame_Done <= px_valid && complete && (row == ROW_LAST) && (col == COL_LAST);
            if (px_valid) begin
                if (complete) Data_Out <= win_flat;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Table-driven bench for conv_window_gen on a 6x6 single-channel frame, stride 1 and stride 2 instances.
// Build with CONV_WINDOW_ZERO_PAD_EN to run the zero-border scenario instead of the unpadded ones.
module tb_conv_window_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        in_ready, in_ready2;
    logic [71:0] do1, do2;
    logic        vo1, vo2, fd1, fd2;

    always #5 clk = ~clk;

    conv_window_gen #(.DATA_WIDHT(8), .CHANNEL_IN(1), .IMG_WIDHT(6), .IMG_HEIGHT(6), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .Valid_In(valid_in), .Data_In(data_in), .In_Ready(in_ready),
        .Data_Out(do1), .Valid_Out(vo1), .Frame_Done(fd1));

    conv_window_gen #(.DATA_WIDHT(8), .CHANNEL_IN(1), .IMG_WIDHT(6), .IMG_HEIGHT(6), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .Valid_In(valid_in), .Data_In(data_in), .In_Ready(in_ready2),
        .Data_Out(do2), .Valid_Out(vo2), .Frame_Done(fd2));

    typedef struct {
        logic [71:0] d;
        logic        fd;
        int          acc;
    } rec_t;

    typedef struct {
        int grp;
        int sel;
        int idx;
        int acc;
        int e[9];
        bit fd;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    rec_t q1[$], q2[$];
    int   acc = 0, b2b = 0, ir_cnt = 0, ir_diff = 0;
    logic vo1_prev = 1'b0;
    int   checks = 0, errors = 0;

    always @(posedge clk) if (valid_in && in_ready) acc++;

    always @(negedge clk) begin
        if (vo1) q1.push_back('{do1, fd1, acc});
        if (vo2) q2.push_back('{do2, fd2, acc});
        if (vo1 && vo1_prev) b2b++;
        vo1_prev = vo1;
        if (in_ready) ir_cnt++;
        if (in_ready !== in_ready2) ir_diff++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int e[9]);
        logic [71:0] v = '0;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(e[k]);
        return v;
    endfunction

    function automatic int fd_count(input int sel, input int from);
        int n = 0;
        if (sel == 1) begin
            for (int i = from; i < q1.size(); i++) n += int'(q1[i].fd);
        end else begin
            for (int i = from; i < q2.size(); i++) n += int'(q2[i].fd);
        end
        return n;
    endfunction

    task automatic send_px(input int v);
        int   n = 0;
        logic took;
        valid_in = 1'b1;
        data_in  = 8'(v);
        do begin
            took = in_ready;
            @(negedge clk);
            n++;
        end while (!took && n < 200);
        if (!took) check("accept timeout", 128'(took), 128'(1));
        valid_in = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gap);
        for (int i = 0; i < 36; i++) begin
            send_px(base + i);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic run_table(input int grp, input int s1, input int s2, input int a0);
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].grp == grp) begin
                int    pos;
                int    n;
                rec_t  r;
                string tag;
                tag = $sformatf("g%0d dut%0d win%0d", grp, tbl[i].sel, tbl[i].idx);
                if (tbl[i].sel == 1) begin
                    pos = s1 + tbl[i].idx;
                    n   = q1.size();
                end else begin
                    pos = s2 + tbl[i].idx;
                    n   = q2.size();
                end
                check({tag, " present"}, 128'(pos < n), 128'(1));
                if (pos < n) begin
                    if (tbl[i].sel == 1) r = q1[pos];
                    else                 r = q2[pos];
                    check({tag, " data"}, 128'(r.d), 128'(pack9(tbl[i].e)));
                    check({tag, " frame_done"}, 128'(r.fd), 128'(tbl[i].fd));
                    if (tbl[i].acc >= 0) check({tag, " accepts"}, 128'(r.acc - a0), 128'(tbl[i].acc));
                end
            end
        end
    endtask

    initial begin
        int s1, s2, a0, b0, i0;
        int e16[9], e31[9];

        // grp 0: unpadded 6x6 frame of raster indices; acc = pixels accepted when the window appears.
        tbl[0]  = '{0, 1, 0,  15, '{0, 1, 2, 6, 7, 8, 12, 13, 14},     1'b0};
        tbl[1]  = '{0, 1, 1,  16, '{1, 2, 3, 7, 8, 9, 13, 14, 15},     1'b0};
        tbl[2]  = '{0, 1, 4,  21, '{6, 7, 8, 12, 13, 14, 18, 19, 20},  1'b0};
        tbl[3]  = '{0, 1, 15, 36, '{21, 22, 23, 27, 28, 29, 33, 34, 35}, 1'b1};
        tbl[4]  = '{0, 2, 0,  15, '{0, 1, 2, 6, 7, 8, 12, 13, 14},     1'b0};
        tbl[5]  = '{0, 2, 1,  17, '{2, 3, 4, 8, 9, 10, 14, 15, 16},    1'b0};
        tbl[6]  = '{0, 2, 2,  27, '{12, 13, 14, 18, 19, 20, 24, 25, 26}, 1'b0};
        tbl[7]  = '{0, 2, 3,  29, '{14, 15, 16, 20, 21, 22, 26, 27, 28}, 1'b1};
        // grp 1: zero-padded frame.
        tbl[8]  = '{1, 1, 0,  -1, '{0, 0, 0, 0, 0, 1, 0, 6, 7},        1'b0};
        tbl[9]  = '{1, 1, 6,  -1, '{0, 0, 1, 0, 6, 7, 0, 12, 13},      1'b0};
        tbl[10] = '{1, 1, 35, -1, '{28, 29, 0, 34, 35, 0, 0, 0, 0},    1'b1};
        tbl[11] = '{1, 2, 0,  -1, '{0, 0, 0, 0, 0, 1, 0, 6, 7},        1'b0};
        tbl[12] = '{1, 2, 8,  -1, '{21, 22, 23, 27, 28, 29, 33, 34, 35}, 1'b1};

        e16 = '{100, 101, 102, 106, 107, 108, 112, 113, 114};
        e31 = '{121, 122, 123, 127, 128, 129, 133, 134, 135};

        rst      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (2) @(negedge clk);
        check("reset valid_out",  128'(vo1), 128'(0));
        check("reset frame_done", 128'(fd1), 128'(0));
        check("reset data_out",   128'(do1), 128'(0));
        check("reset in_ready",   128'(in_ready), 128'(0));
        rst = 1'b1;
        #1;
`ifndef CONV_WINDOW_ZERO_PAD_EN
        check("in_ready after reset", 128'(in_ready), 128'(1));
        @(negedge clk);

        // Continuous stream.
        s1 = q1.size(); s2 = q2.size(); a0 = acc;
        send_frame(0, 1'b0);
        repeat (5) @(negedge clk);
        check("s1 window count",  128'(q1.size() - s1), 128'(16));
        check("s2 window count",  128'(q2.size() - s2), 128'(4));
        check("s1 frame_done cnt", 128'(fd_count(1, s1)), 128'(1));
        check("s2 frame_done cnt", 128'(fd_count(2, s2)), 128'(1));
        run_table(0, s1, s2, a0);

        // Valid_In toggling 1,0,1,0.
        s1 = q1.size(); s2 = q2.size(); a0 = acc; b0 = b2b;
        send_frame(0, 1'b1);
        repeat (5) @(negedge clk);
        check("gap s1 window count", 128'(q1.size() - s1), 128'(16));
        check("gap s2 window count", 128'(q2.size() - s2), 128'(4));
        check("gap back-to-back valid", 128'(b2b - b0), 128'(0));
        run_table(0, s1, s2, a0);

        // Reset after 20 pixels, then a clean frame.
        for (int i = 0; i < 20; i++) send_px(50 + i);
        rst = 1'b0;
        #1;
        check("midreset valid_out",  128'(vo1), 128'(0));
        check("midreset frame_done", 128'(fd1), 128'(0));
        check("midreset data_out",   128'(do1), 128'(0));
        check("midreset in_ready",   128'(in_ready), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s1 = q1.size(); s2 = q2.size(); a0 = acc;
        send_frame(0, 1'b0);
        repeat (5) @(negedge clk);
        check("midreset s1 count", 128'(q1.size() - s1), 128'(16));
        check("midreset s2 count", 128'(q2.size() - s2), 128'(4));
        run_table(0, s1, s2, a0);

        // Two frames with no gap.
        s1 = q1.size(); s2 = q2.size(); a0 = acc;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        repeat (5) @(negedge clk);
        check("b2b s1 count", 128'(q1.size() - s1), 128'(32));
        check("b2b s2 count", 128'(q2.size() - s2), 128'(8));
        check("b2b s1 frame_done cnt", 128'(fd_count(1, s1)), 128'(2));
        check("b2b s2 frame_done cnt", 128'(fd_count(2, s2)), 128'(2));
        run_table(0, s1, s2, a0);
        if (q1.size() - s1 >= 32) begin
            check("b2b f2 first data",   128'(q1[s1+16].d), 128'(pack9(e16)));
            check("b2b f2 first accepts", 128'(q1[s1+16].acc - a0), 128'(51));
            check("b2b f2 first fd",     128'(q1[s1+16].fd), 128'(0));
            check("b2b f2 last data",    128'(q1[s1+31].d), 128'(pack9(e31)));
            check("b2b f2 last fd",      128'(q1[s1+31].fd), 128'(1));
        end
`else
        check("in_ready idle", 128'(in_ready), 128'(0));
        @(negedge clk);
        s1 = q1.size(); s2 = q2.size(); a0 = acc; i0 = ir_cnt;
        send_frame(0, 1'b0);
        repeat (25) @(negedge clk);
        check("pad s1 count", 128'(q1.size() - s1), 128'(36));
        check("pad s2 count", 128'(q2.size() - s2), 128'(9));
        check("pad s1 frame_done cnt", 128'(fd_count(1, s1)), 128'(1));
        check("pad s2 frame_done cnt", 128'(fd_count(2, s2)), 128'(1));
        check("pad in_ready cycles", 128'(ir_cnt - i0), 128'(36));
        check("pad in_ready agree", 128'(ir_diff), 128'(0));
        check("pad in_ready idle after", 128'(in_ready), 128'(0));
        run_table(1, s1, s2, a0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
